// File: rtl/puf_chal_framer.sv
// puf_chal_framer: host-byte to PUF-challenge framer.
// Frame layout: header, channel, CHAL_W/8 payload bytes (LSB first), and then
// an XOR checksum byte for normal frames only. A debug frame carries no checksum.
// Optional feature macro: PUF_FRAME_TIMEOUT_EN enables the inter-byte timeout.
//
// Handshakes: a byte moves on s_valid && s_ready, and a challenge moves on
// m_valid && m_ready. A producer holds valid and its data stable until the
// matching ready is seen. s_ready is low only while a challenge waits in OUT.
module puf_chal_framer #(
  parameter int         BYTE_W      = 8,
  parameter int         CHAL_W      = 128,
  parameter int         NUM_PUF     = 4,
  parameter logic [7:0] NORM_MOD    = 8'd34,
  parameter logic [7:0] DEBUG_MOD   = 8'd133,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BYTE_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CHAL_W-1:0]          m_chal,
  output logic [$clog2(NUM_PUF)-1:0] m_ch,
  output logic                       m_debug,
  output logic                       err_pulse,
  output logic [1:0]                 err_code
);

  localparam int NBYTES = CHAL_W / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam int CH_W   = $clog2(NUM_PUF);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NBYTES - 1);
  localparam logic [BYTE_W:0]   NUM_PUF_B = (BYTE_W + 1)'(NUM_PUF);

  // Parameter sanity, caught at elaboration.
  if (BYTE_W != 8 || (CHAL_W % 8) != 0 || CHAL_W < 16 || NUM_PUF < 2 || TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("puf_chal_framer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHAN    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   xor_q, xor_d;
  logic [CHAL_W-1:0]   chal_buf_q, chal_buf_d;
  logic [CH_W-1:0]     ch_buf_q, ch_buf_d;
  logic                dbg_buf_q, dbg_buf_d;
  logic [CHAL_W-1:0]   m_chal_q, m_chal_d;
  logic [CH_W-1:0]     m_ch_q, m_ch_d;
  logic                m_debug_q, m_debug_d;
  logic                err_pulse_q, err_pulse_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                accept;

`ifdef PUF_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`endif

  assign accept = s_valid && s_ready;

  // State register; reset drops any partial frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: frame assembly buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      xor_q       <= '0;
      chal_buf_q  <= '0;
      ch_buf_q    <= '0;
      dbg_buf_q   <= 1'b0;
      m_chal_q    <= '0;
      m_ch_q      <= '0;
      m_debug_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
`ifdef PUF_FRAME_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      xor_q       <= xor_d;
      chal_buf_q  <= chal_buf_d;
      ch_buf_q    <= ch_buf_d;
      dbg_buf_q   <= dbg_buf_d;
      m_chal_q    <= m_chal_d;
      m_ch_q      <= m_ch_d;
      m_debug_q   <= m_debug_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
`ifdef PUF_FRAME_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Next-state and frame parsing: a byte is consumed only when it is accepted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xor_d       = xor_q;
    chal_buf_d  = chal_buf_q;
    ch_buf_d    = ch_buf_q;
    dbg_buf_d   = dbg_buf_q;
    m_chal_d    = m_chal_q;
    m_ch_d      = m_ch_q;
    m_debug_d   = m_debug_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (s_data == NORM_MOD || s_data == DEBUG_MOD) begin
            state_d   = ST_CHAN;
            dbg_buf_d = (s_data == DEBUG_MOD);
            xor_d     = s_data;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = 2'd1;
          end
        end
      end
      ST_CHAN: begin
        if (accept) begin
          if ({1'b0, s_data} < NUM_PUF_B) begin
            state_d  = ST_PAYLOAD;
            ch_buf_d = s_data[CH_W-1:0];
            xor_d    = xor_q ^ s_data;
            cnt_d    = '0;
          end else begin
            state_d     = ST_IDLE;
            xor_d       = '0;
            cnt_d       = '0;
            err_pulse_d = 1'b1;
            err_code_d  = 2'd2;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          chal_buf_d[BYTE_W*cnt_q +: BYTE_W] = s_data;
          xor_d = xor_q ^ s_data;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = dbg_buf_q ? ST_OUT : ST_CSUM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          xor_d = '0;
          if (s_data == xor_q) begin
            state_d = ST_OUT;
          end else begin
            state_d     = ST_IDLE;
            err_pulse_d = 1'b1;
            err_code_d  = 2'd3;
          end
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d = ST_IDLE;
          xor_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        xor_d   = '0;
        cnt_d   = '0;
      end
    endcase

`ifdef PUF_FRAME_TIMEOUT_EN
    // Stall counter runs only mid-frame; any accepted byte restarts it.
    to_cnt_d = '0;
    if ((state_q == ST_CHAN || state_q == ST_PAYLOAD || state_q == ST_CSUM) && !accept) begin
      if (to_cnt_q == TO_LAST) begin
        state_d     = ST_IDLE;
        xor_d       = '0;
        cnt_d       = '0;
        err_pulse_d = 1'b1;
        err_code_d  = 2'd0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif

    // Outputs load only on entry to OUT so they stay stable while m_valid is high.
    if (state_d == ST_OUT && state_q != ST_OUT) begin
      m_chal_d  = chal_buf_d;
      m_ch_d    = ch_buf_d;
      m_debug_d = dbg_buf_d;
    end
  end

  // Output decode from the current state and registered datapath.
  always_comb begin
    s_ready   = (state_q != ST_OUT);
    m_valid   = (state_q == ST_OUT);
    m_chal    = m_chal_q;
    m_ch      = m_ch_q;
    m_debug   = m_debug_q;
    err_pulse = err_pulse_q;
    err_code  = err_code_q;
  end

endmodule

// File: tb/tb_puf_chal_framer.sv
// tb_puf_chal_framer: directed bench for puf_chal_framer (CHAL_W=32, NUM_PUF=4,
// TIMEOUT_CYC=16). Follows PUF_FRAME_TIMEOUT_EN to pick the timeout scenario.
module tb_puf_chal_framer;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_chal;
  logic [1:0]  m_ch;
  logic        m_debug;
  logic        err_pulse;
  logic [1:0]  err_code;

  int n_assert;
  int n_fail;
  int err_cnt;
  int out_cnt;
  int exp_err;
  logic [1:0]  last_code;
  logic [34:0] exp_q[$];   // {debug, ch, chal}

  puf_chal_framer #(
    .BYTE_W(8), .CHAL_W(32), .NUM_PUF(4),
    .NORM_MOD(8'd34), .DEBUG_MOD(8'd133), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_chal(m_chal),
    .m_ch(m_ch), .m_debug(m_debug),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  // Clock and run-time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte; returns just after the clock edge that accepted it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("send_ready", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_norm(input logic [7:0] ch, input logic [31:0] chal);
    logic [7:0] cs;
    cs = 8'h22 ^ ch ^ chal[7:0] ^ chal[15:8] ^ chal[23:16] ^ chal[31:24];
    send(8'h22); send(ch);
    send(chal[7:0]); send(chal[15:8]); send(chal[23:16]); send(chal[31:24]);
    send(cs);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: error strobes and completed challenges.
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst_n && err_pulse) begin
      err_cnt++;
      last_code = err_code;
    end
    if (rst_n && m_valid && m_ready) begin
      out_cnt++;
      check("out_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_chal", m_chal, e[31:0]);
        check("out_ch", m_ch, e[33:32]);
        check("out_debug", m_debug, e[34]);
      end
    end
  end

  initial begin
    n_assert = 0; n_fail = 0; err_cnt = 0; out_cnt = 0; exp_err = 0;
    last_code = 2'd0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_chal", m_chal, 32'h0);
    check("rst_m_ch", m_ch, 2'd0);
    check("rst_m_debug", m_debug, 1'b0);
    check("rst_err_pulse", err_pulse, 1'b0);
    check("rst_err_code", err_code, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Normal frame 22 01 AA BB CC DD 23.
    exp_q.push_back({1'b0, 2'd1, 32'hDDCCBBAA});
    send(8'h22); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'h23);
    @(negedge clk);
    check("norm_m_valid_rise", m_valid, 1'b1);
    check("norm_s_ready_out", s_ready, 1'b0);
    check("norm_no_err", err_pulse, 1'b0);
    @(negedge clk);
    check("norm_m_valid_fall", m_valid, 1'b0);
    check("norm_s_ready_back", s_ready, 1'b1);
    idle(1);
    check("norm_out_cnt", out_cnt, 1);
    check("norm_err_cnt", err_cnt, 0);

    // Debug frame, then 22 immediately parsed as a new header.
    exp_q.push_back({1'b1, 2'd3, 32'h44332211});
    send(8'h85); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk);
    check("dbg_m_valid_rise", m_valid, 1'b1);
    idle(1);
    exp_q.push_back({1'b0, 2'd2, 32'h04030201});
    send(8'h22); send(8'h02); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h24);
    idle(2);
    check("dbg_out_cnt", out_cnt, 3);
    check("dbg_err_cnt", err_cnt, 0);

    // Bad header 55, next byte taken as a header in the error cycle.
    exp_q.push_back({1'b0, 2'd1, 32'hDDCCBBAA});
    send(8'h55);
    send_norm(8'h01, 32'hDDCCBBAA);
    idle(2);
    check("hdr_err_cnt", err_cnt, 1);
    check("hdr_err_code", last_code, 2'd1);
    check("hdr_out_cnt", out_cnt, 4);

    // Bad channel 04.
    send(8'h22); send(8'h04);
    @(negedge clk);
    check("chan_err_pulse", err_pulse, 1'b1);
    check("chan_err_code", err_code, 2'd2);
    @(negedge clk);
    check("chan_err_single", err_pulse, 1'b0);
    idle(1);
    check("chan_err_cnt", err_cnt, 2);

    // Bad checksum 24 instead of 23.
    send(8'h22); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'h24);
    @(negedge clk);
    check("csum_err_pulse", err_pulse, 1'b1);
    check("csum_err_code", err_code, 2'd3);
    check("csum_no_valid", m_valid, 1'b0);
    @(negedge clk);
    check("csum_no_valid2", m_valid, 1'b0);
    check("csum_err_single", err_pulse, 1'b0);
    idle(1);
    check("csum_out_cnt", out_cnt, 4);
    check("csum_err_cnt", err_cnt, 3);

    // Back-pressure: m_ready low for 5 cycles.
    m_ready = 1'b0;
    exp_q.push_back({1'b0, 2'd1, 32'hDDCCBBAA});
    send_norm(8'h01, 32'hDDCCBBAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid", m_valid, 1'b1);
      check("bp_s_ready", s_ready, 1'b0);
      check("bp_m_chal", m_chal, 32'hDDCCBBAA);
      check("bp_m_ch", m_ch, 2'd1);
      check("bp_m_debug", m_debug, 1'b0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_m_valid_fall", m_valid, 1'b0);
    check("bp_s_ready_back", s_ready, 1'b1);
    idle(1);
    check("bp_out_cnt", out_cnt, 5);

    // Stall mid-payload after 22 01 AA.
    send(8'h22); send(8'h01); send(8'hAA);
    idle(14);
    check("to_no_early_err", err_cnt, 3);
`ifdef PUF_FRAME_TIMEOUT_EN
    idle(4);
    check("to_err_cnt", err_cnt, 4);
    check("to_err_code", last_code, 2'd0);
    exp_err = 4;
    exp_q.push_back({1'b0, 2'd1, 32'hDDCCBBAA});
    send_norm(8'h01, 32'hDDCCBBAA);
`else
    idle(6);
    check("to_no_err", err_cnt, 3);
    exp_err = 3;
    exp_q.push_back({1'b0, 2'd1, 32'hDDCCBBAA});
    send(8'hBB); send(8'hCC); send(8'hDD); send(8'h23);
`endif
    idle(2);
    check("to_out_cnt", out_cnt, 6);

    // Reset during payload.
    send(8'h85); send(8'h02); send(8'h55);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_s_ready", s_ready, 1'b1);
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_m_chal", m_chal, 32'h0);
    check("mid_rst_m_ch", m_ch, 2'd0);
    check("mid_rst_m_debug", m_debug, 1'b0);
    check("mid_rst_err_pulse", err_pulse, 1'b0);
    check("mid_rst_err_code", err_code, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back({1'b1, 2'd2, 32'h04030201});
    send(8'h85); send(8'h02); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    @(negedge clk);
    check("post_rst_m_valid", m_valid, 1'b1);
    idle(3);

    // Final bookkeeping.
    check("final_q_empty", exp_q.size(), 0);
    check("final_out_cnt", out_cnt, 7);
    check("final_err_cnt", err_cnt, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
